// File: rtl/uart_csr_bank.sv
// UART control/status register bank: CPU-visible registers, staged configuration and
// divisor with idle-gated apply, sticky interrupt status, and RX/TX FIFO access ports.
module uart_csr_bank #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DIV_WIDTH  = 16,
    parameter logic [DIV_WIDTH-1:0]  DIV_RESET  = 16'd54,
    parameter int                    THR_WIDTH  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  write_i,
    input  logic                  read_i,
    input  logic [3:0]            address_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  error_o,
    input  logic                  tx_idle_i,
    input  logic                  rx_idle_i,
    output logic [DIV_WIDTH-1:0]  divisor_o,
    output logic                  divisor_load_o,
    output logic [1:0]            data_width_o,
    output logic [1:0]            parity_mode_o,
    output logic [1:0]            stop_bits_o,
    output logic                  cfg_update_o,
    output logic [THR_WIDTH-1:0]  rx_threshold_o,
    input  logic [3:0]            event_i,
    output logic                  irq_o,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_fifo_empty_i,
    output logic                  rx_fifo_read_o,
    input  logic                  tx_fifo_full_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_fifo_write_o
);

    localparam int         NCHUNK    = DIV_WIDTH / DATA_WIDTH;
    localparam logic [2:0] TOP_CHUNK = 3'(NCHUNK - 1);
    localparam logic [5:0] CFG_RESET = 6'b00_00_11;

    localparam logic [3:0] A_CFG = 4'h0;
    localparam logic [3:0] A_FSR = 4'h1;
    localparam logic [3:0] A_IER = 4'h2;
    localparam logic [3:0] A_ISR = 4'h3;
    localparam logic [3:0] A_RXR = 4'h4;
    localparam logic [3:0] A_TXR = 4'h5;
    localparam logic [3:0] A_PND = 4'h6;

    logic [5:0]            cfg_staged;
    logic                  cfg_pend;
    logic [DIV_WIDTH-1:0]  div_shadow;
    logic                  div_pend;
    logic [DATA_WIDTH-1:0] ier;
    logic [4:0]            isr;
    logic                  txf_q;
    logic                  rxe_q;

    logic                  rd_en;
    logic                  collide;
    logic                  is_div;
    logic                  mapped;
    logic                  cfg_we;
    logic                  fsr_we;
    logic                  ier_we;
    logic                  isr_we;
    logic                  txr_we;
    logic                  div_we;
    logic                  div_top_we;
    logic                  rxr_rd;
    logic                  err;
    logic                  cfg_apply;
    logic                  div_apply;
    logic [4:0]            isr_set;
    logic [4:0]            isr_clr;
    logic [4:0]            isr_next;
    logic [DATA_WIDTH-1:0] rd_val;

    // A simultaneous write and read performs the write only; the read is dropped.
    assign collide    = write_i && read_i;
    assign rd_en      = read_i && !write_i;
    assign is_div     = address_i[3] && (address_i[2:0] < 3'(NCHUNK));
    assign mapped     = (address_i < 4'h7) || is_div;

    assign cfg_we     = write_i && (address_i == A_CFG);
    assign fsr_we     = write_i && (address_i == A_FSR);
    assign ier_we     = write_i && (address_i == A_IER);
    assign isr_we     = write_i && (address_i == A_ISR);
    assign txr_we     = write_i && (address_i == A_TXR);
    assign div_we     = write_i && is_div;
    assign div_top_we = div_we && (address_i[2:0] == TOP_CHUNK);
    assign rxr_rd     = rd_en && (address_i == A_RXR);

    assign rx_fifo_read_o = rxr_rd && !rx_fifo_empty_i;

    assign err = (write_i || read_i) &&
                 (!mapped || collide || (rxr_rd && rx_fifo_empty_i));

    assign cfg_apply = cfg_pend && tx_idle_i && rx_idle_i;
    assign div_apply = div_pend && tx_idle_i && rx_idle_i;

    // New events win over a same-cycle write-1-to-clear.
    assign isr_set  = {txr_we && tx_fifo_full_i, event_i};
    assign isr_clr  = isr_we ? wdata_i[4:0] : 5'd0;
    assign isr_next = (isr & ~isr_clr) | isr_set;

    always_comb begin
        rd_val = '0;
        case (address_i)
            A_CFG: rd_val[5:0] = cfg_staged;
            A_FSR: begin
                rd_val[THR_WIDTH-1:0] = rx_threshold_o;
                rd_val[6]             = txf_q;
                rd_val[7]             = rxe_q;
            end
            A_IER: rd_val = ier;
            A_ISR: rd_val[4:0] = isr;
            A_RXR: begin
                if (!rx_fifo_empty_i) begin
                    rd_val[7:0] = rx_data_i;
                end
            end
            A_PND: rd_val[1:0] = {div_pend, cfg_pend};
            default: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (is_div && (address_i[2:0] == 3'(k))) begin
                        rd_val = div_shadow[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_o         <= '0;
            rvalid_o        <= 1'b0;
            error_o         <= 1'b0;
            cfg_staged      <= CFG_RESET;
            cfg_pend        <= 1'b0;
            data_width_o    <= CFG_RESET[1:0];
            parity_mode_o   <= CFG_RESET[3:2];
            stop_bits_o     <= CFG_RESET[5:4];
            cfg_update_o    <= 1'b0;
            div_shadow      <= DIV_RESET;
            div_pend        <= 1'b0;
            divisor_o       <= DIV_RESET;
            divisor_load_o  <= 1'b0;
            rx_threshold_o  <= '0;
            ier             <= '0;
            isr             <= '0;
            irq_o           <= 1'b0;
            txf_q           <= 1'b0;
            rxe_q           <= 1'b1;
            tx_data_o       <= '0;
            tx_fifo_write_o <= 1'b0;
        end else begin
            rvalid_o <= rd_en;
            if (rd_en) begin
                rdata_o <= rd_val;
            end
            error_o <= err;

            txf_q <= tx_fifo_full_i;
            rxe_q <= rx_fifo_empty_i;

            if (fsr_we) begin
                rx_threshold_o <= wdata_i[THR_WIDTH-1:0];
            end
            if (ier_we) begin
                ier <= wdata_i;
            end
            isr   <= isr_next;
            irq_o <= |(isr & ier[4:0]);

            tx_fifo_write_o <= txr_we && !tx_fifo_full_i;
            if (txr_we && !tx_fifo_full_i) begin
                tx_data_o <= wdata_i[7:0];
            end

            // Apply uses the value staged before this cycle; a same-cycle write re-arms pending.
            cfg_update_o <= cfg_apply;
            if (cfg_apply) begin
                data_width_o  <= cfg_staged[1:0];
                parity_mode_o <= cfg_staged[3:2];
                stop_bits_o   <= cfg_staged[5:4];
            end
            if (cfg_we) begin
                cfg_staged <= wdata_i[5:0];
            end
            cfg_pend <= cfg_we || (cfg_pend && !cfg_apply);

            divisor_load_o <= div_apply;
            if (div_apply) begin
                divisor_o <= div_shadow;
            end
            for (int k = 0; k < NCHUNK; k++) begin
                if (div_we && (address_i[2:0] == 3'(k))) begin
                    div_shadow[k*DATA_WIDTH +: DATA_WIDTH] <= wdata_i;
                end
            end
            div_pend <= div_top_we || (div_pend && !div_apply);
        end
    end

endmodule
